// File: rtl/ascii_dec2bin.sv
// ASCII decimal-to-binary converter: collects decimal digits into a BCD register,
// then converts BCD to binary with one reverse double-dabble iteration per cycle.
module ascii_dec2bin #(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  overflow,
    output logic                  fmt_err,
    output logic                  busy
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int BIN_W  = DATA_WIDTH + 1;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int ITER_W = $clog2(DATA_WIDTH + 2);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state;
    logic [BCD_W-1:0]  bcd;
    logic [BIN_W-1:0]  bin;
    logic [CNT_W-1:0]  count;
    logic [ITER_W-1:0] iter;
    logic              seen_digit;
    logic              too_many;
    logic              bad_char;

    logic              accept;
    logic              is_digit;
    logic              is_term;
    logic              leading_zero;
    logic              ovf_now;

    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]       bcd_nx;
    logic [BIN_W-1:0]       bin_nx;

    assign rx_ready     = (state == COLLECT);
    assign busy         = (state != COLLECT);
    assign accept       = rx_valid && rx_ready;
    assign is_digit     = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_term      = (rx_data == 8'h0D) || (rx_data == 8'h0A) || (rx_data == 8'h20);
    assign leading_zero = (bcd == '0) && (rx_data[3:0] == 4'd0);
    assign ovf_now      = too_many || bin[DATA_WIDTH];

    // One reverse double-dabble step: shift right, then pull every nibble >= 8 down by 3.
    always_comb begin
        shifted = {bcd, bin} >> 1;
        bcd_nx  = shifted[BCD_W+BIN_W-1 -: BCD_W];
        bin_nx  = shifted[BIN_W-1:0];
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_nx[4*i +: 4] >= 4'd8)
                bcd_nx[4*i +: 4] = bcd_nx[4*i +: 4] - 4'd3;
        end
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            bcd        <= '0;
            bin        <= '0;
            count      <= '0;
            iter       <= '0;
            seen_digit <= 1'b0;
            too_many   <= 1'b0;
            bad_char   <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            fmt_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (is_digit) begin
                            seen_digit <= 1'b1;
                            if (!leading_zero) begin
                                if (count == CNT_W'(DIGITS)) begin
                                    too_many <= 1'b1;
                                end else begin
                                    bcd   <= (bcd << 4) | BCD_W'(rx_data[3:0]);
                                    count <= count + 1'b1;
                                end
                            end
                        end else if (is_term) begin
                            // Empty terminators with nothing to report are swallowed.
                            if (seen_digit || too_many || bad_char) begin
                                state <= CONVERT;
                                iter  <= '0;
                                bin   <= '0;
                            end
                        end else begin
                            bad_char <= 1'b1;
                        end
                    end
                end

                CONVERT: begin
                    bcd <= bcd_nx;
                    bin <= bin_nx;
                    if (iter == ITER_W'(DATA_WIDTH)) begin
                        state <= DONE;
                    end else begin
                        iter <= iter + 1'b1;
                    end
                end

                DONE: begin
                    data_valid <= 1'b1;
                    fmt_err    <= bad_char;
                    overflow   <= ovf_now;
                    if (bad_char)
                        data_out <= '0;
                    else if (ovf_now)
                        data_out <= '1;
                    else
                        data_out <= bin[DATA_WIDTH-1:0];
                    bcd        <= '0;
                    count      <= '0;
                    seen_digit <= 1'b0;
                    too_many   <= 1'b0;
                    bad_char   <= 1'b0;
                    state      <= COLLECT;
                end

                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_dec2bin.sv
// Self-checking bench for ascii_dec2bin: integer-arithmetic reference model,
// per-cycle output comparison, and directed strings with literal expectations.
module tb_ascii_dec2bin;

    localparam int DW      = 16;
    localparam int NDIG    = 5;
    localparam int LATENCY = DW + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          overflow;
    logic          fmt_err;
    logic          busy;

    ascii_dec2bin #(.DATA_WIDTH(DW), .DIGITS(NDIG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overflow   (overflow),
        .fmt_err    (fmt_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: value accumulated as an integer from the character stream.
    int          cyc = 0;
    longint      m_val;
    int          m_cnt;
    bit          m_seen, m_many, m_bad;
    bit          pending = 0;
    int          due;
    logic [DW-1:0] exp_out, held_out;
    bit          exp_ovf, exp_fmt, held_ovf, held_fmt;

    function automatic void model_clear();
        m_val  = 0;
        m_cnt  = 0;
        m_seen = 0;
        m_many = 0;
        m_bad  = 0;
    endfunction

    function automatic void model_char(input logic [7:0] c);
        int d;
        if (c >= 8'h30 && c <= 8'h39) begin
            d = int'(c) - 48;
            m_seen = 1;
            if (!(m_val == 0 && d == 0)) begin
                if (m_cnt == NDIG) m_many = 1;
                else begin
                    m_val = m_val * 10 + d;
                    m_cnt++;
                end
            end
        end else if (c == 8'h0D || c == 8'h0A || c == 8'h20) begin
            if (m_seen || m_many || m_bad) begin
                exp_ovf = m_many || (m_val > 65535);
                exp_fmt = m_bad;
                exp_out = m_bad ? '0 : (exp_ovf ? '1 : DW'(m_val));
                due     = cyc + LATENCY;
                pending = 1;
                model_clear();
            end
        end else begin
            m_bad = 1;
        end
    endfunction

    initial model_clear();

    always @(posedge clk) begin
        if (!rst_n) begin
            model_clear();
            pending  = 0;
            held_out = '0;
            held_ovf = 0;
            held_fmt = 0;
        end else begin
            cyc++;
            if (rx_valid && rx_ready) model_char(rx_data);
        end
    end

    int          dv_count = 0;
    int          dv_cyc   = 0;
    logic [DW-1:0] dv_log[$];

    // Compare process: every cycle out of reset, sampled on the falling edge.
    always @(negedge clk) begin
        bit exp_busy;
        if (rst_n) begin
            exp_busy = pending && (cyc < due);
            check("busy", busy, exp_busy);
            check("rx_ready", rx_ready, !exp_busy);
            if (pending && cyc == due) begin
                check("data_valid_pulse", data_valid, 1'b1);
                check("data_out", data_out, exp_out);
                check("overflow", overflow, exp_ovf);
                check("fmt_err", fmt_err, exp_fmt);
                held_out = exp_out;
                held_ovf = exp_ovf;
                held_fmt = exp_fmt;
                pending  = 0;
            end else begin
                check("data_valid_idle", data_valid, 1'b0);
                check("data_out_hold", data_out, held_out);
                check("overflow_hold", overflow, held_ovf);
                check("fmt_err_hold", fmt_err, held_fmt);
            end
            if (data_valid) begin
                dv_log.push_back(data_out);
                dv_count++;
                dv_cyc = cyc;
            end
        end
    end

    // Drives a string with rx_valid held high; each character waits for rx_ready.
    task automatic send(input string s);
        int w;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = s[i];
            w = 0;
            while (!rx_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (!rx_ready) check("accept_timeout", rx_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_log(input int n, input int limit);
        int w = 0;
        while (dv_log.size() < n && w < limit) begin
            @(negedge clk);
            w++;
        end
        check("result_count", dv_log.size(), n);
    endtask

    task automatic run(input string name, input string s, input logic [DW-1:0] lit_out,
                       input bit lit_ovf, input bit lit_fmt);
        dv_log.delete();
        send(s);
        wait_log(1, 40);
        check({name, "_out"}, (dv_log.size() > 0) ? dv_log[0] : 'x, lit_out);
        check({name, "_ovf"}, overflow, lit_ovf);
        check({name, "_fmt"}, fmt_err, lit_fmt);
    endtask

    initial begin
        int t0, d0;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #3;
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_fmt_err", fmt_err, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rx_ready", rx_ready, 1'b1);

        dv_log.delete();
        send("12345\r");
        t0 = cyc;
        wait_log(1, 40);
        check("n12345_out", (dv_log.size() > 0) ? dv_log[0] : 'x, 16'h3039);
        check("n12345_latency", dv_cyc - t0, LATENCY);
        check("n12345_ovf", overflow, 0);
        check("n12345_fmt", fmt_err, 0);

        run("n65535", "65535\n", 16'hFFFF, 0, 0);
        run("n65536", "65536 ", 16'hFFFF, 1, 0);
        run("n123456", "123456\r", 16'hFFFF, 1, 0);
        run("n0000042", "0000042\r", 16'd42, 0, 0);
        run("n0", "0\r", 16'd0, 0, 0);

        d0 = dv_count;
        send("\r");
        repeat (25) @(negedge clk);
        check("bare_cr_no_pulse", dv_count, d0);

        run("n1a2", "1a2\r", 16'd0, 0, 1);
        run("n7", "7\r", 16'd7, 0, 0);

        dv_log.delete();
        send("9\r3\r");
        wait_log(2, 40);
        check("b2b_first", (dv_log.size() > 0) ? dv_log[0] : 'x, 16'd9);
        check("b2b_second", (dv_log.size() > 1) ? dv_log[1] : 'x, 16'd3);

        d0 = dv_count;
        send("99\r");
        repeat (5) @(posedge clk);
        #2;
        check("abort_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_data_out", data_out, 0);
        check("abort_data_valid", data_valid, 0);
        check("abort_overflow", overflow, 0);
        check("abort_fmt_err", fmt_err, 0);
        check("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_rx_ready", rx_ready, 1'b1);
        repeat (30) @(negedge clk);
        check("abort_no_pulse", dv_count, d0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
